uart_loopback_fifo: RTL and testbench

Parametrised UART loopback engine placed between the `uart_rx` and `uart_tx` instances in the top level, replacing the single-byte loopback register. Received words are buffered in a FIFO of configurable depth. A drain FSM returns them to the transmitter over the `txDataValid`/`txBusy` handshake. An optional line mode holds data until an end-of-line character arrives, and a sticky overflow flag reports dropped words.

---
 rtl/uart_loopback_pkg.sv | 14 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_loopback_fifo.sv | 136 +++++++++++++
 tb/tb_uart_loopback_fifo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loopback_pkg.sv
// Shared drain FSM states and constants for the UART loopback FIFO engine.
package uart_loopback_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } drain_state_t;

    localparam int STAT_W = 16;
    localparam logic [7:0] DEFAULT_EOL_CHAR = 8'h0D;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered storage with first-word-fall-through head on dout.
// Latency: a push is visible on dout/level the cycle after; a pop advances the head the cycle after.
// Backpressure: push is ignored while full, pop is ignored while empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + (AW+1)'(1);
            else if (!do_push && do_pop) level <= level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_loopback_fifo.sv
// UART loopback engine: buffers rx words and drains them to uart_tx; stats ports under UART_LOOPBACK_STATS_EN.
// Latency: rx strobe in cycle N reaches txDataValid in N+2 when idle; strobes are at least 3 cycles apart.
// Backpressure: words wait while txBusy or line mode holds them; a push into a full FIFO is dropped and flags overflow.
module uart_loopback_fifo
    import uart_loopback_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    DEPTH        = 16,
    parameter int                    LINE_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] EOL_CHAR     = DATA_WIDTH'(DEFAULT_EOL_CHAR),
    parameter int                    BUSY_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   rxData,
    input  logic                    rxDataValid,
    output logic [DATA_WIDTH-1:0]   txData,
    output logic                    txDataValid,
    input  logic                    txBusy,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow
`ifdef UART_LOOPBACK_STATS_EN
    ,
    output logic [STAT_W-1:0]       rx_count,
    output logic [STAT_W-1:0]       tx_count,
    output logic [STAT_W-1:0]       drop_count
`endif
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    drain_state_t          state;
    drain_state_t          state_nxt;
    logic [TW-1:0]         to_cnt;
    logic [TW-1:0]         to_cnt_nxt;
    logic [DATA_WIDTH-1:0] head;
    logic [LW-1:0]         eol_pending;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  permit;
    logic                  eol_in;
    logic                  eol_out;

    // Full check uses the registered level: a same-cycle pop never makes room.
    assign push    = rxDataValid && !full;
    assign drop    = rxDataValid && full;
    assign eol_in  = push && (rxData == EOL_CHAR);
    assign eol_out = pop && (head == EOL_CHAR);
    assign permit  = (LINE_MODE == 0) || (eol_pending != '0) || full;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rxData),
        .dout  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    // The head is popped on the edge into LOAD so txData/txDataValid are registered during LOAD.
    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !txBusy && permit) begin
                    state_nxt = LOAD;
                    pop       = 1'b1;
                end
            end
            LOAD: begin
                state_nxt  = WAIT_BUSY;
                to_cnt_nxt = '0;
            end
            WAIT_BUSY: begin
                if (txBusy)                              state_nxt = WAIT_DONE;
                else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) state_nxt = IDLE;
                else                                     to_cnt_nxt = to_cnt + TW'(1);
            end
            WAIT_DONE: begin
                if (!txBusy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txData      <= '0;
            txDataValid <= 1'b0;
            overflow    <= 1'b0;
            eol_pending <= '0;
        end else begin
            txDataValid <= pop;
            if (pop)  txData   <= head;
            if (drop) overflow <= 1'b1;
            if (eol_in && !eol_out)      eol_pending <= eol_pending + LW'(1);
            else if (!eol_in && eol_out) eol_pending <= eol_pending - LW'(1);
        end
    end

`ifdef UART_LOOPBACK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count   <= '0;
            tx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (push && (rx_count != '1))           rx_count   <= rx_count + STAT_W'(1);
            if ((state == LOAD) && (tx_count != '1)) tx_count   <= tx_count + STAT_W'(1);
            if (drop && (drop_count != '1))         drop_count <= drop_count + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Bench for uart_loopback_fifo: echo-mode DUT (DEPTH 16) with a busy model, line-mode DUT (DEPTH 4) with txBusy tied low.
module tb_uart_loopback_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Echo-mode DUT
    logic        rst_a = 1'b1;
    logic [7:0]  rx_a = 8'h00;
    logic        rxv_a = 1'b0;
    logic [7:0]  tx_a;
    logic        txv_a;
    logic        busy_a;
    logic [4:0]  lvl_a;
    logic        ovf_a;
    logic        busy_force = 1'b0;
    bit          model_en = 1'b0;
    int          busy_cnt = 0;

    // Line-mode DUT
    logic        rst_b = 1'b1;
    logic [7:0]  rx_b = 8'h00;
    logic        rxv_b = 1'b0;
    logic [7:0]  tx_b;
    logic        txv_b;
    logic        busy_b = 1'b0;
    logic [2:0]  lvl_b;
    logic        ovf_b;

`ifdef UART_LOOPBACK_STATS_EN
    logic [15:0] rxc_a, txc_a, dropc_a, rxc_b, txc_b, dropc_b;
`endif

    uart_loopback_fifo #(.DATA_WIDTH(8), .DEPTH(16), .LINE_MODE(0), .EOL_CHAR(8'h0D), .BUSY_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst_a), .rxData(rx_a), .rxDataValid(rxv_a),
        .txData(tx_a), .txDataValid(txv_a), .txBusy(busy_a),
        .fifo_level(lvl_a), .overflow(ovf_a)
`ifdef UART_LOOPBACK_STATS_EN
        , .rx_count(rxc_a), .tx_count(txc_a), .drop_count(dropc_a)
`endif
    );

    uart_loopback_fifo #(.DATA_WIDTH(8), .DEPTH(4), .LINE_MODE(1), .EOL_CHAR(8'h0D), .BUSY_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst_b), .rxData(rx_b), .rxDataValid(rxv_b),
        .txData(tx_b), .txDataValid(txv_b), .txBusy(busy_b),
        .fifo_level(lvl_b), .overflow(ovf_b)
`ifdef UART_LOOPBACK_STATS_EN
        , .rx_count(rxc_b), .tx_count(txc_b), .drop_count(dropc_b)
`endif
    );

    // Transmitter model: busy for 10 cycles after each load strobe.
    assign busy_a = busy_force | (busy_cnt != 0);
    always @(negedge clk) begin
        if (txv_a && model_en) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    end

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int t_a[$];
    int n_strobe_a = 0;
    int n_strobe_b = 0;
    int last_a = -100;
    int last_b = -100;

    always @(negedge clk) begin
        if (txv_a) begin
            n_strobe_a++;
            t_a.push_back(cyc);
            check("gap_a", 32'(cyc - last_a >= 3), 32'd1);
            last_a = cyc;
            check("pending_a", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) check("data_a", 32'(tx_a), 32'(exp_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (txv_b) begin
            n_strobe_b++;
            check("gap_b", 32'(cyc - last_b >= 3), 32'd1);
            last_b = cyc;
            check("pending_b", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) check("data_b", 32'(tx_b), 32'(exp_b.pop_front()));
        end
    end

    task automatic push_a(input logic [7:0] d, input bit expect_out);
        @(negedge clk);
        rx_a = d;
        rxv_a = 1'b1;
        if (expect_out) exp_a.push_back(d);
        @(negedge clk);
        rxv_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d, input bit expect_out);
        @(negedge clk);
        rx_b = d;
        rxv_b = 1'b1;
        if (expect_out) exp_b.push_back(d);
        @(negedge clk);
        rxv_b = 1'b0;
    endtask

    task automatic wait_idle_a(input string name, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (exp_a.size() == 0) && (lvl_a == 5'd0) && !busy_a;
        end
        check(name, 32'(done), 32'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_idle_b(input string name, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (exp_b.size() == 0) && (lvl_b == 3'd0);
        end
        check(name, 32'(done), 32'd1);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        check("rst_txdata", 32'(tx_a), 32'h0);
        check("rst_txvalid", 32'(txv_a), 32'h0);
        check("rst_level", 32'(lvl_a), 32'h0);
        check("rst_overflow", 32'(ovf_a), 32'h0);
        check("rst_level_b", 32'(lvl_b), 32'h0);

        // Single echo: strobe 2 cycles after the rx strobe, level 0->1->0.
        @(negedge clk);
        rx_a = 8'h41;
        rxv_a = 1'b1;
        exp_a.push_back(8'h41);
        check("echo_lvl0", 32'(lvl_a), 32'd0);
        @(negedge clk);
        rxv_a = 1'b0;
        check("echo_lvl1", 32'(lvl_a), 32'd1);
        check("echo_novalid", 32'(txv_a), 32'd0);
        @(negedge clk);
        check("echo_valid", 32'(txv_a), 32'd1);
        check("echo_data", 32'(tx_a), 32'h41);
        check("echo_lvl2", 32'(lvl_a), 32'd0);
        wait_idle_a("echo_done", 50);
        check("echo_hold", 32'(tx_a), 32'h41);

        // Burst under busy, then drained with a 10-cycle busy per word.
        busy_force = 1'b1;
        s0 = n_strobe_a;
        for (int i = 0; i < 5; i++) push_a(8'h30 + 8'(i), 1'b1);
        repeat (3) @(negedge clk);
        check("burst_level", 32'(lvl_a), 32'd5);
        check("burst_held", 32'(n_strobe_a - s0), 32'd0);
        model_en = 1'b1;
        busy_force = 1'b0;
        wait_idle_a("burst_drain", 200);
        check("burst_count", 32'(n_strobe_a - s0), 32'd5);
        check("burst_no_ovf", 32'(ovf_a), 32'd0);

        // Overflow: 18 pushes into 16 entries, only the first 16 come back.
        busy_force = 1'b1;
        for (int i = 0; i < 18; i++) push_a(8'h60 + 8'(i), i < 16);
        @(negedge clk);
        check("ovf_level", 32'(lvl_a), 32'd16);
        check("ovf_flag", 32'(ovf_a), 32'd1);
`ifdef UART_LOOPBACK_STATS_EN
        check("ovf_drop_count", 32'(dropc_a), 32'd2);
        check("ovf_rx_count", 32'(rxc_a), 32'd22);
`endif
        busy_force = 1'b0;
        wait_idle_a("ovf_drain", 600);
        check("ovf_sticky", 32'(ovf_a), 32'd1);

        // Busy timeout: txBusy never rises, strobes every 1+4+1 cycles.
        model_en = 1'b0;
        t_a.delete();
        for (int i = 0; i < 3; i++) push_a(8'hA0 + 8'(i), 1'b1);
        wait_idle_a("timeout_drain", 100);
        check("timeout_strobes", 32'(t_a.size()), 32'd3);
        if (t_a.size() == 3) begin
            check("timeout_gap1", 32'(t_a[1] - t_a[0]), 32'd6);
            check("timeout_gap2", 32'(t_a[2] - t_a[1]), 32'd6);
        end

        // Reset while in WAIT_DONE with 3 words queued.
        model_en = 1'b1;
        busy_force = 1'b1;
        push_a(8'hC0, 1'b1);
        for (int i = 1; i < 4; i++) push_a(8'hC0 + 8'(i), 1'b0);
        s0 = n_strobe_a;
        busy_force = 1'b0;
        n = 0;
        while (n_strobe_a == s0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_first_strobe", 32'(n_strobe_a - s0), 32'd1);
        repeat (4) @(negedge clk);
        check("rstmid_queued", 32'(lvl_a), 32'd3);
        check("rstmid_ovf_before", 32'(ovf_a), 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("rstmid_level", 32'(lvl_a), 32'd0);
        check("rstmid_ovf", 32'(ovf_a), 32'd0);
        check("rstmid_novalid", 32'(txv_a), 32'd0);
        repeat (40) @(negedge clk);
        check("rstmid_silent", 32'(n_strobe_a - s0), 32'd1);

        // Line mode: "ab" held until CR arrives.
        push_b(8'h61, 1'b0);
        push_b(8'h62, 1'b0);
        repeat (10) @(negedge clk);
        check("line_held", 32'(n_strobe_b), 32'd0);
        check("line_level", 32'(lvl_b), 32'd2);
        exp_b.push_back(8'h61);
        exp_b.push_back(8'h62);
        push_b(8'h0D, 1'b1);
        wait_idle_b("line_drain", 100);
        check("line_count", 32'(n_strobe_b), 32'd3);
        check("line_eol_pending", 32'(dut_b.eol_pending), 32'd0);

        // A full FIFO with no CR releases one word per full condition.
        push_b(8'h77, 1'b0);
        push_b(8'h78, 1'b0);
        push_b(8'h79, 1'b0);
        exp_b.push_back(8'h77);
        push_b(8'h7A, 1'b0);
        repeat (20) @(negedge clk);
        check("flush_count", 32'(n_strobe_b), 32'd4);
        check("flush_level", 32'(lvl_b), 32'd3);
        check("flush_no_ovf", 32'(ovf_b), 32'd0);
        exp_b.push_back(8'h78);
        exp_b.push_back(8'h79);
        exp_b.push_back(8'h7A);
        push_b(8'h0D, 1'b1);
        wait_idle_b("flush_drain", 100);
        check("flush_total", 32'(n_strobe_b), 32'd8);
        check("flush_eol_pending", 32'(dut_b.eol_pending), 32'd0);

        check("final_exp_a", 32'(exp_a.size()), 32'd0);
        check("final_exp_b", 32'(exp_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
